// File: rtl/fp_mul_product_normalize_if.sv
// Handshake and data bundle between the partial-product stage, the product
// normalizer and the FP result packer.
interface fp_mul_product_normalize_if #(
  parameter int FractionSize = 23,
  parameter int ExpWidth     = 10
);
  logic                    InValid;
  logic                    InReady;
  logic [15:0]             Result11, Result12, Result13;
  logic [15:0]             Result21, Result22, Result23;
  logic [15:0]             Result31, Result32, Result33;
  logic                    Sign;
  logic [ExpWidth-1:0]     ExpIn;
  logic                    OutValid;
  logic                    OutReady;
  logic                    SignOut;
  logic [FractionSize-1:0] FractionOut;
  logic [7:0]              ExponentOut;
  logic                    Overflow;
  logic                    Underflow;

  modport master (
    output InValid, Result11, Result12, Result13, Result21, Result22, Result23,
           Result31, Result32, Result33, Sign, ExpIn, OutReady,
    input  InReady, OutValid, SignOut, FractionOut, ExponentOut, Overflow, Underflow
  );

  modport slave (
    input  InValid, Result11, Result12, Result13, Result21, Result22, Result23,
           Result31, Result32, Result33, Sign, ExpIn, OutReady,
    output InReady, OutValid, SignOut, FractionOut, ExponentOut, Overflow, Underflow
  );
endinterface

// File: rtl/fp_mul_product_normalize.sv
// FP multiplier stage 2: partial products -> 48-bit product -> normalized fraction.
// Define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_mul_product_normalize #(
  parameter int FractionSize = 23,
  parameter int ExpWidth     = 10
) (
  input logic Clk,
  input logic Reset,
  fp_mul_product_normalize_if.slave bus
);
  localparam int STAGES = 3;
  localparam int PW     = 2 * (FractionSize + 1);
  localparam int EW1    = ExpWidth + 1;

  logic [STAGES:1] vld_pipe;
  logic ld1, ld2, ld3;

  // A stage may load when empty or when its content leaves this cycle.
  assign ld3 = !vld_pipe[3] || bus.OutReady;
  assign ld2 = !vld_pipe[2] || ld3;
  assign ld1 = !vld_pipe[1] || ld2;
  assign bus.InReady = ld1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vld_pipe <= '0;
    else begin
      if (ld1) vld_pipe[1] <= bus.InValid;
      if (ld2) vld_pipe[2] <= vld_pipe[1];
      if (ld3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  // S1: column sums of the byte partial products
  logic [15:0]         s1_c0, s1_c32;
  logic [16:0]         s1_c8, s1_c24;
  logic [17:0]         s1_c16;
  logic                s1_sign;
  logic [ExpWidth-1:0] s1_exp;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_c0   <= '0;
      s1_c8   <= '0;
      s1_c16  <= '0;
      s1_c24  <= '0;
      s1_c32  <= '0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
    end else if (ld1 && bus.InValid) begin
      s1_c0   <= bus.Result11;
      s1_c8   <= 17'(bus.Result12) + 17'(bus.Result21);
      s1_c16  <= 18'(bus.Result13) + 18'(bus.Result22) + 18'(bus.Result31);
      s1_c24  <= 17'(bus.Result23) + 17'(bus.Result32);
      s1_c32  <= bus.Result33;
      s1_sign <= bus.Sign;
      s1_exp  <= bus.ExpIn;
    end
  end

  // S2: full product; both mantissas have the hidden bit so P fits in PW bits
  logic [PW-1:0]       p_sum, s2_p;
  logic                s2_sign;
  logic [ExpWidth-1:0] s2_exp;

  assign p_sum = PW'(s1_c0) + (PW'(s1_c8) << 8) + (PW'(s1_c16) << 16)
               + (PW'(s1_c24) << 24) + (PW'(s1_c32) << 32);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_p    <= '0;
      s2_sign <= 1'b0;
      s2_exp  <= '0;
    end else if (ld2 && vld_pipe[1]) begin
      s2_p    <= p_sum;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
    end
  end

  // S3: normalize to 1.xxx, round, adjust exponent
  logic [FractionSize-1:0] frac_sel, frac_fin;
  logic [EW1-1:0]          e_base, e_fin;

  always_comb begin
    frac_sel = s2_p[PW-1] ? s2_p[PW-2 -: FractionSize] : s2_p[PW-3 -: FractionSize];
    e_base   = {s2_exp[ExpWidth-1], s2_exp} + {{ExpWidth{1'b0}}, s2_p[PW-1]};
  end

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic guard, sticky, rnd_cy;

  always_comb begin
    if (s2_p[PW-1]) begin
      guard  = s2_p[PW-2-FractionSize];
      sticky = |s2_p[PW-3-FractionSize:0];
    end else begin
      guard  = s2_p[PW-3-FractionSize];
      sticky = |s2_p[PW-4-FractionSize:0];
    end
    // All-ones fraction wraps to zero and the carry bumps the exponent
    {rnd_cy, frac_fin} = {1'b0, frac_sel}
                       + (FractionSize+1)'(guard && (sticky || frac_sel[0]));
    e_fin = e_base + {{(EW1-1){1'b0}}, rnd_cy};
  end
`else
  logic unused_lsbs;

  // Bits below the kept fraction only matter when rounding
  assign unused_lsbs = |s2_p[PW-3-FractionSize:0];
  assign frac_fin    = frac_sel;
  assign e_fin       = e_base;
`endif

  logic                    sign_q, ovf_q, unf_q;
  logic [FractionSize-1:0] frac_q;
  logic [7:0]              expo_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sign_q <= 1'b0;
      frac_q <= '0;
      expo_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (ld3 && vld_pipe[2]) begin
      sign_q <= s2_sign;
      frac_q <= frac_fin;
      expo_q <= e_fin[7:0];
      ovf_q  <= !e_fin[EW1-1] && (e_fin >= EW1'(255));
      unf_q  <= e_fin[EW1-1] || (e_fin == '0);
    end
  end

  assign bus.OutValid    = vld_pipe[STAGES];
  assign bus.SignOut     = sign_q;
  assign bus.FractionOut = frac_q;
  assign bus.ExponentOut = expo_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;

endmodule
